gemm_axil_regs: RTL and testbench
=================================

Name: gemm_axil_regs

Overview:
AXI4-Lite slave (responder) register block for the GEMM accelerator, on the far end of the host/bench AXI-Lite write/read initiator. It decodes host writes into configuration registers and a one-cycle start pulse for the GEMM core, and returns status on reads. It sits inside `top` between the S_AXI_* pins and the GEMM datapath control.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers, decode on ADDR[4:2]
VERSION, 32'h0001_0000, constant returned by the VERSION register

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
start_o  out  1  one-cycle start pulse to GEMM core
size_m_o / size_n_o / size_k_o  out  16 each  matrix dimensions
busy_i  in  1  core busy level
done_i  in  1  core completion pulse

Behaviour:
- Reset (async assert, sync release): AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, start_o=0, all RW regs 0, sticky bits 0.
- Register map (byte offset):
  - 0x00 CTRL: write bit0=1 -> start; reads 0.
  - 0x04 STATUS: bit0 busy_i (RO), bit1 done (sticky, W1C), bit2 start_err (sticky, W1C).
  - 0x08 SIZE_M, 0x0C SIZE_N, 0x10 SIZE_K: RW, [15:0].
  - 0x14 SCRATCH: RW 32 bit.
  - 0x18 VERSION: RO.
  - 0x1C IRQ_EN: RW bit0.
- Offsets above 0x1C are unmapped (only reachable with C_S_AXI_ADDR_WIDTH>5).
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1.
  - AW and W valid in the same cycle: accept both, commit at that edge, go to W_RESP with BVALID=1 next cycle. The bench pulses AW/W for exactly one cycle, so same-cycle acceptance is mandatory.
  - Only AW valid: latch address, AWREADY=0, go to W_WAITW. Only W valid: latch data and strobes, WREADY=0, go to W_WAITA. Commit when the partner arrives, then go to W_RESP.
  - W_RESP: hold BVALID and BRESP until BREADY, then W_IDLE with readies high on the following cycle.
- WSTRB: RW regs update only the enabled byte lanes. W1C and CTRL act on byte 0 only when WSTRB[0]=1.
- BRESP: OKAY for mapped offsets. SLVERR (2'b10) for unmapped or RO offsets (VERSION); those writes are ignored.
- Read FSM states:
  - R_IDLE: ARREADY=1. On ARVALID, register RDATA/RRESP from current register state, go to R_DATA (ARREADY=0, RVALID=1).
  - R_DATA: hold until RREADY, then R_IDLE.
  - Unmapped read: RDATA=0, RRESP=SLVERR.
- Read/write to the same register in the same cycle: the read returns the pre-write value.
- start_o: high exactly one cycle, the cycle after the CTRL commit edge.
  - Start requested while busy_i=1: no pulse, set start_err.
  - start_o is also suppressed while a previous start_o is high (back-to-back).
- done sticky: set on done_i. done_i coincident with a W1C of bit1: set wins.
- Reset mid-transaction: all FSMs return to IDLE immediately and pending BVALID/RVALID drop.

Optional Feature:
GEMM_AXIL_IRQ_EN:
- Defined: adds port irq_o (out, 1), registered, = STATUS.done & IRQ_EN[0]; reset 0; deasserts the cycle after W1C clears done.
- Undefined: no irq_o port. IRQ_EN still exists as a plain RW bit.

Decomposition:
- Package gemm_axil_pkg:
  - Register offset localparams (CTRL_OFS .. IRQ_EN_OFS).
  - RESP_OKAY / RESP_SLVERR constants.
  - Write/read FSM state enums.
  - STATUS bit-index constants.
- Sub-module gemm_axil_wstrb_reg: a 32-bit byte-strobed RW register with reset, instantiated for SIZE_M/N/K, SCRATCH and IRQ_EN.
- The FSMs stay in the top module.

Test Plan:
- Write 0x08<=0x0000_0040 with AW+W one cycle, BREADY=1 -> AWREADY/WREADY high at accept, BVALID=1 one cycle later with BRESP=0; read 0x08 -> RDATA=0x40, RRESP=0.
- WSTRB=4'b0010 write 0x14<=0xAABBCCDD after SCRATCH=0x11223344 -> read 0x14 = 0x1122CC44.
- AW alone (cycle t), W at t+3 -> AWREADY=0 during t+1..t+3, commit at t+3, BVALID at t+4; W-first ordering gives the symmetric result.
- Write CTRL=1 with busy_i=0 -> start_o high exactly one cycle; with busy_i=1 -> no pulse, STATUS reads 0x5; write STATUS=0x4 -> STATUS reads 0x1.
- Pulse done_i -> STATUS bit1=1 (irq_o=1 with GEMM_AXIL_IRQ_EN and IRQ_EN=1); W1C bit1 coincident with a new done_i -> bit1 stays 1.
- Read 0x18 -> 0x0001_0000 OKAY; write 0x18 -> BRESP=2'b10, value unchanged; assert reset while BVALID=1 -> BVALID=0 immediately, AWREADY=1 after release.

Source files
------------

// File: rtl/gemm_axil_pkg.sv
// Shared constants and FSM state types for the GEMM AXI4-Lite register block.
package gemm_axil_pkg;

   localparam logic [4:0] CTRL_OFS    = 5'h00;
   localparam logic [4:0] STATUS_OFS  = 5'h04;
   localparam logic [4:0] SIZE_M_OFS  = 5'h08;
   localparam logic [4:0] SIZE_N_OFS  = 5'h0C;
   localparam logic [4:0] SIZE_K_OFS  = 5'h10;
   localparam logic [4:0] SCRATCH_OFS = 5'h14;
   localparam logic [4:0] VERSION_OFS = 5'h18;
   localparam logic [4:0] IRQ_EN_OFS  = 5'h1C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_WAITW = 2'd1,
      W_WAITA = 2'd2,
      W_RESP  = 2'd3
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

endpackage

// File: rtl/gemm_axil_wstrb_reg.sv
// Byte-strobed read/write register; each bit follows the strobe of its byte lane.
module gemm_axil_wstrb_reg #(
   parameter int WIDTH = 32,
   parameter int LANES = (WIDTH + 7) / 8
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             en,
   input  logic [LANES-1:0] strb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         q <= '0;
      end else if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (strb[i/8]) q[i] <= d[i];
         end
      end
   end

endmodule

// File: rtl/gemm_axil_regs.sv
// AXI4-Lite register block for the GEMM core: config registers, start pulse, status.
// Optional irq_o output is built when GEMM_AXIL_IRQ_EN is defined.
//
// write FSM state | meaning
// W_IDLE          | AWREADY=WREADY=1, waiting for address and/or data
// W_WAITW         | address latched, waiting for write data
// W_WAITA         | data/strobes latched, waiting for write address
// W_RESP          | BVALID=1, holding BRESP until BREADY
// read FSM state  | meaning
// R_IDLE          | ARREADY=1, waiting for read address
// R_DATA          | RVALID=1, holding RDATA/RRESP until RREADY
module gemm_axil_regs
   import gemm_axil_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [31:0] VERSION            = 32'h0001_0000
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            start_o,
   output logic [15:0]                     size_m_o,
   output logic [15:0]                     size_n_o,
   output logic [15:0]                     size_k_o,
   input  logic                            busy_i,
   input  logic                            done_i
`ifdef GEMM_AXIL_IRQ_EN
   ,output logic                           irq_o
`endif
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [AW-1:0] aw_addr_q;
   logic [31:0]   w_data_q;
   logic [3:0]    w_strb_q;
   logic          commit, lat_aw, lat_w;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_strb;
   logic [1:0]    bresp_q;

   logic sel_ctrl, sel_status, sel_m, sel_n, sel_k, sel_scratch, sel_irq;
   logic wr_err;
   logic [31:0] scratch_q;
   logic [0:0]  irq_en_q;
   logic        done_q, err_q, start_req, w1c_ok;
   logic [31:0] status_w, rd_data;
   logic        rd_err;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state   <= W_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (lat_aw) aw_addr_q <= S_AXI_AWADDR;
         if (lat_w) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // A commit always uses the live bus side for whichever channel arrived last.
   always_comb begin
      w_next  = w_state;
      commit  = 1'b0;
      lat_aw  = 1'b0;
      lat_w   = 1'b0;
      wr_addr = aw_addr_q;
      wr_data = w_data_q;
      wr_strb = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               commit  = 1'b1;
               wr_addr = S_AXI_AWADDR;
               wr_data = S_AXI_WDATA;
               wr_strb = S_AXI_WSTRB;
               w_next  = W_RESP;
            end else if (S_AXI_AWVALID) begin
               lat_aw = 1'b1;
               w_next = W_WAITW;
            end else if (S_AXI_WVALID) begin
               lat_w  = 1'b1;
               w_next = W_WAITA;
            end
         end
         W_WAITW: begin
            if (S_AXI_WVALID) begin
               commit  = 1'b1;
               wr_data = S_AXI_WDATA;
               wr_strb = S_AXI_WSTRB;
               w_next  = W_RESP;
            end
         end
         W_WAITA: begin
            if (S_AXI_AWVALID) begin
               commit  = 1'b1;
               wr_addr = S_AXI_AWADDR;
               w_next  = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_WAITA);
   assign S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_WAITW);
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = bresp_q;

   always_comb begin
      sel_ctrl    = 1'b0;
      sel_status  = 1'b0;
      sel_m       = 1'b0;
      sel_n       = 1'b0;
      sel_k       = 1'b0;
      sel_scratch = 1'b0;
      sel_irq     = 1'b0;
      wr_err      = 1'b1;
      if ((wr_addr >> 5) == '0) begin
         wr_err = 1'b0;
         case ({wr_addr[4:2], 2'b00})
            CTRL_OFS:    sel_ctrl    = 1'b1;
            STATUS_OFS:  sel_status  = 1'b1;
            SIZE_M_OFS:  sel_m       = 1'b1;
            SIZE_N_OFS:  sel_n       = 1'b1;
            SIZE_K_OFS:  sel_k       = 1'b1;
            SCRATCH_OFS: sel_scratch = 1'b1;
            IRQ_EN_OFS:  sel_irq     = 1'b1;
            default:     wr_err      = 1'b1;
         endcase
      end
   end

   gemm_axil_wstrb_reg #(.WIDTH(16)) u_size_m (
      .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .en(commit && sel_m),
      .strb(wr_strb[1:0]), .d(wr_data[15:0]), .q(size_m_o));
   gemm_axil_wstrb_reg #(.WIDTH(16)) u_size_n (
      .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .en(commit && sel_n),
      .strb(wr_strb[1:0]), .d(wr_data[15:0]), .q(size_n_o));
   gemm_axil_wstrb_reg #(.WIDTH(16)) u_size_k (
      .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .en(commit && sel_k),
      .strb(wr_strb[1:0]), .d(wr_data[15:0]), .q(size_k_o));
   gemm_axil_wstrb_reg #(.WIDTH(32)) u_scratch (
      .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .en(commit && sel_scratch),
      .strb(wr_strb), .d(wr_data), .q(scratch_q));
   gemm_axil_wstrb_reg #(.WIDTH(1)) u_irq_en (
      .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .en(commit && sel_irq),
      .strb(wr_strb[0]), .d(wr_data[0]), .q(irq_en_q));

   assign start_req = commit && sel_ctrl && wr_strb[0] && wr_data[0];
   assign w1c_ok    = commit && sel_status && wr_strb[0];

   // Sticky bits: a new set event beats a coincident W1C.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         start_o <= 1'b0;
      end else begin
         done_q  <= done_i || (done_q && !(w1c_ok && wr_data[STAT_DONE]));
         err_q   <= (start_req && busy_i) || (err_q && !(w1c_ok && wr_data[STAT_ERR]));
         start_o <= start_req && !busy_i && !start_o;
      end
   end

`ifdef GEMM_AXIL_IRQ_EN
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) irq_o <= 1'b0;
      else                irq_o <= done_q && irq_en_q[0];
   end
`endif

   always_comb begin
      status_w            = '0;
      status_w[STAT_BUSY] = busy_i;
      status_w[STAT_DONE] = done_q;
      status_w[STAT_ERR]  = err_q;
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      if ((S_AXI_ARADDR >> 5) == '0) begin
         rd_err = 1'b0;
         case ({S_AXI_ARADDR[4:2], 2'b00})
            CTRL_OFS:    rd_data = '0;
            STATUS_OFS:  rd_data = status_w;
            SIZE_M_OFS:  rd_data = {16'd0, size_m_o};
            SIZE_N_OFS:  rd_data = {16'd0, size_n_o};
            SIZE_K_OFS:  rd_data = {16'd0, size_k_o};
            SCRATCH_OFS: rd_data = scratch_q;
            VERSION_OFS: rd_data = VERSION;
            IRQ_EN_OFS:  rd_data = {31'd0, irq_en_q};
            default:     rd_err  = 1'b1;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state     <= R_IDLE;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         if (r_state == R_IDLE && S_AXI_ARVALID) begin
            S_AXI_RDATA <= rd_err ? '0 : rd_data;
            S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (S_AXI_ARVALID) r_next = R_DATA;
         R_DATA:  if (S_AXI_RREADY)  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   assign S_AXI_ARREADY = (r_state == R_IDLE);
   assign S_AXI_RVALID  = (r_state == R_DATA);

   // Registers are word-aligned; byte-offset bits carry no information.
   logic unused_bits;
`ifdef GEMM_AXIL_IRQ_EN
   assign unused_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0]};
`else
   assign unused_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0], irq_en_q};
`endif

endmodule

// File: tb/tb_gemm_axil_regs.sv
// Directed bench for gemm_axil_regs: vector table plus split-channel, start, done and reset sequences.
module tb_gemm_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b1, rready = 1'b1;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, start_o;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [15:0] size_m, size_n, size_k;
   logic        busy = 1'b0, done = 1'b0;
`ifdef GEMM_AXIL_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   gemm_axil_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .start_o(start_o), .size_m_o(size_m), .size_n_o(size_n), .size_k_o(size_k),
      .busy_i(busy), .done_i(done)
`ifdef GEMM_AXIL_IRQ_EN
      , .irq_o(irq)
`endif
   );

   always @(negedge clk) if (start_o) start_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_bvalid();
      int n = 0;
      while (!bvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("b_latency", n, 0);
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      @(posedge clk); #1;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      check("aw_w_ready", {30'd0, awready, wready}, 32'h3);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      wait_bvalid();
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1;
      check("arready", {31'd0, arready}, 32'h1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      while (!rvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("r_latency", n, 0);
      d = rdata; resp = rresp;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[16];
   logic [31:0] rd;
   logic [1:0]  rsp;
   int          cnt0;

   initial begin
      vecs[0]  = '{1, 5'h08, 32'h0000_0040, 4'hF, 32'h0, 2'b00};
      vecs[1]  = '{0, 5'h08, 32'h0,         4'h0, 32'h0000_0040, 2'b00};
      vecs[2]  = '{1, 5'h14, 32'h1122_3344, 4'hF, 32'h0, 2'b00};
      vecs[3]  = '{1, 5'h14, 32'hAABB_CCDD, 4'b0010, 32'h0, 2'b00};
      vecs[4]  = '{0, 5'h14, 32'h0,         4'h0, 32'h1122_CC44, 2'b00};
      vecs[5]  = '{0, 5'h18, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
      vecs[6]  = '{1, 5'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10};
      vecs[7]  = '{0, 5'h18, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
      vecs[8]  = '{1, 5'h0C, 32'hFFFF_1234, 4'hF, 32'h0, 2'b00};
      vecs[9]  = '{0, 5'h0C, 32'h0,         4'h0, 32'h0000_1234, 2'b00};
      vecs[10] = '{1, 5'h10, 32'h0000_0ABC, 4'b0001, 32'h0, 2'b00};
      vecs[11] = '{0, 5'h10, 32'h0,         4'h0, 32'h0000_00BC, 2'b00};
      vecs[12] = '{1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00};
      vecs[13] = '{0, 5'h1C, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
      vecs[14] = '{0, 5'h00, 32'h0,         4'h0, 32'h0, 2'b00};
      vecs[15] = '{0, 5'h04, 32'h0,         4'h0, 32'h0, 2'b00};

      #12;
      check("rst_ready", {29'd0, awready, wready, arready}, 32'h7);
      check("rst_valid", {30'd0, bvalid, rvalid}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_start", {31'd0, start_o}, 32'h0);
      check("rst_sizes", {size_m, size_n}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
            check($sformatf("vec%0d_bresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
         end else begin
            axi_read(vecs[i].addr, rd, rsp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_rresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
         end
      end
      check("size_m_port", {16'd0, size_m}, 32'h40);

      // AW first, W three cycles later
      @(posedge clk); #1;
      awaddr = 5'h08; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("awfirst_awready_low", {31'd0, awready}, 32'h0);
         check("awfirst_no_bvalid", {31'd0, bvalid}, 32'h0);
         if (c < 2) begin @(posedge clk); #1; end
      end
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      check("awfirst_wready", {31'd0, wready}, 32'h1);
      @(posedge clk); #1;
      wvalid = 1'b0;
      check("awfirst_bvalid", {31'd0, bvalid}, 32'h1);
      check("awfirst_commit", {16'd0, size_m}, 32'h77);
      @(posedge clk); #1;

      // W first, AW three cycles later
      wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("wfirst_wready_low", {31'd0, wready}, 32'h0);
         check("wfirst_no_bvalid", {31'd0, bvalid}, 32'h0);
         if (c < 2) begin @(posedge clk); #1; end
      end
      awaddr = 5'h0C; awvalid = 1'b1;
      check("wfirst_awready", {31'd0, awready}, 32'h1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("wfirst_bvalid", {31'd0, bvalid}, 32'h1);
      check("wfirst_commit", {16'd0, size_n}, 32'h99);
      @(posedge clk); #1;

      // Same-cycle read and write of SCRATCH returns the old value
      awaddr = 5'h14; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h14; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("rw_same_cycle_old", rdata, 32'h1122_CC44);
      @(posedge clk); #1;
      axi_read(5'h14, rd, rsp);
      check("rw_same_cycle_new", rd, 32'hCAFE_F00D);

      // Start pulses
      cnt0 = start_cnt;
      axi_write(5'h00, 32'h1, 4'hF, rsp);
      repeat (3) @(posedge clk);
      #1;
      check("start_one_pulse", start_cnt - cnt0, 1);
      busy = 1'b1;
      cnt0 = start_cnt;
      axi_write(5'h00, 32'h1, 4'hF, rsp);
      repeat (3) @(posedge clk);
      #1;
      check("start_busy_none", start_cnt - cnt0, 0);
      axi_read(5'h04, rd, rsp);
      check("status_busy_err", rd, 32'h5);
      axi_write(5'h04, 32'h4, 4'hF, rsp);
      axi_read(5'h04, rd, rsp);
      check("status_err_clr", rd, 32'h1);
      busy = 1'b0;

      // done sticky and set-beats-clear
      @(posedge clk); #1;
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      axi_read(5'h04, rd, rsp);
      check("status_done", rd, 32'h2);
      awaddr = 5'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; done = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
      wait_bvalid();
      @(posedge clk); #1;
      axi_read(5'h04, rd, rsp);
      check("done_set_wins", rd, 32'h2);
      axi_write(5'h04, 32'h2, 4'hF, rsp);
      axi_read(5'h04, rd, rsp);
      check("done_w1c", rd, 32'h0);

      // Reset while BVALID is pending
      bready = 1'b0;
      awaddr = 5'h14; wdata = 32'h5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("pre_rst_bvalid", {31'd0, bvalid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_bvalid_drop", {31'd0, bvalid}, 32'h0);
      #3 rst_n = 1'b1;
      bready = 1'b1;
      @(posedge clk); #1;
      check("post_rst_awready", {30'd0, awready, wready}, 32'h3);
      check("post_rst_bvalid", {31'd0, bvalid}, 32'h0);
      axi_read(5'h14, rd, rsp);
      check("post_rst_scratch", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
